// File: rtl/tdm_demux_if.sv
// Bus between a TDM word source and the tdm_demux receiver.
// Signal names carry the i_/o_ direction as seen from the demux (slave) side.
interface tdm_demux_if #(
   parameter int WIDTH = 1
);
   logic [WIDTH-1:0] i_din;
   logic             i_din_valid;
   logic             i_frame_sync;
   logic [WIDTH-1:0] o_a;
   logic [WIDTH-1:0] o_b;
   logic             o_a_valid;
   logic             o_b_valid;
   logic             o_frame_done;
   logic             o_sync_err;
   logic [7:0]       o_err_count;

   modport master (
      output i_din, i_din_valid, i_frame_sync,
      input  o_a, o_b, o_a_valid, o_b_valid, o_frame_done, o_sync_err, o_err_count
   );

   modport slave (
      input  i_din, i_din_valid, i_frame_sync,
      output o_a, o_b, o_a_valid, o_b_valid, o_frame_done, o_sync_err, o_err_count
   );
endinterface

// File: rtl/tdm_demux.sv
// Two-channel TDM demultiplexer: locks on frame_sync-marked A words, steers A/B words
// to registered outputs with strobes. Optional saturating error counter: TDM_DEMUX_ERRCNT_EN.
module tdm_demux #(
   parameter int WIDTH = 1
) (
   input  logic        clk,
   input  logic        rst,
   tdm_demux_if.slave  bus
);

   typedef enum logic [1:0] {
      HUNT  = 2'd0,
      EXP_B = 2'd1,
      EXP_A = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] w_a_nxt;
   logic [WIDTH-1:0] w_b_nxt;
   logic             r_a_valid;
   logic             r_b_valid;
   logic             r_frame_done;
   logic             r_sync_err;
   logic             w_a_valid_nxt;
   logic             w_b_valid_nxt;
   logic             w_frame_done_nxt;
   logic             w_sync_err_nxt;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      w_state_nxt      = r_state;
      w_a_nxt          = r_a;
      w_b_nxt          = r_b;
      w_a_valid_nxt    = 1'b0;
      w_b_valid_nxt    = 1'b0;
      w_frame_done_nxt = 1'b0;
      w_sync_err_nxt   = 1'b0;
      if (bus.i_din_valid) begin
         unique case (r_state)
            HUNT: begin
               if (bus.i_frame_sync) begin
                  w_a_nxt       = bus.i_din;
                  w_a_valid_nxt = 1'b1;
                  w_state_nxt   = EXP_B;
               end
            end
            EXP_B: begin
               if (bus.i_frame_sync) begin
                  // B slot skipped: resynchronise on this new A word.
                  w_sync_err_nxt = 1'b1;
                  w_a_nxt        = bus.i_din;
                  w_a_valid_nxt  = 1'b1;
               end else begin
                  w_b_nxt          = bus.i_din;
                  w_b_valid_nxt    = 1'b1;
                  w_frame_done_nxt = 1'b1;
                  w_state_nxt      = EXP_A;
               end
            end
            EXP_A: begin
               if (bus.i_frame_sync) begin
                  w_a_nxt       = bus.i_din;
                  w_a_valid_nxt = 1'b1;
                  w_state_nxt   = EXP_B;
               end else begin
                  w_sync_err_nxt = 1'b1;
                  w_state_nxt    = HUNT;
               end
            end
            default: w_state_nxt = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= HUNT;
         r_a          <= '0;
         r_b          <= '0;
         r_a_valid    <= 1'b0;
         r_b_valid    <= 1'b0;
         r_frame_done <= 1'b0;
         r_sync_err   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         r_state      <= w_state_nxt;
         r_a          <= w_a_nxt;
         r_b          <= w_b_nxt;
         r_a_valid    <= w_a_valid_nxt;
         r_b_valid    <= w_b_valid_nxt;
         r_frame_done <= w_frame_done_nxt;
         r_sync_err   <= w_sync_err_nxt;
      end
   end

`ifdef TDM_DEMUX_ERRCNT_EN
   logic [7:0] r_err_count;

   // Counts on the same edge that raises sync_err, sticking at 255.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_count <= 8'd0;
      end else if (w_sync_err_nxt && (r_err_count != 8'hFF)) begin
         r_err_count <= r_err_count + 8'd1;
      end
   end

   assign bus.o_err_count = r_err_count;
`else
   assign bus.o_err_count = 8'd0;
`endif

   assign bus.o_a          = r_a;
   assign bus.o_b          = r_b;
   assign bus.o_a_valid    = r_a_valid;
   assign bus.o_b_valid    = r_b_valid;
   assign bus.o_frame_done = r_frame_done;
   assign bus.o_sync_err   = r_sync_err;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed self-checking bench for tdm_demux (WIDTH = 1); expected values are hand-derived.
// Build with TDM_DEMUX_ERRCNT_EN defined to exercise the saturating error counter.
module tb_tdm_demux;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   tdm_demux_if #(.WIDTH(1)) u_if ();

   tdm_demux #(.WIDTH(1)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   always #5 clk = ~clk;

   // One beat: drive at the falling edge, return 1 time unit after the capturing rising edge.
   task automatic beat(input logic sync, input logic din);
      @(negedge clk);
      u_if.i_din_valid  = 1'b1;
      u_if.i_frame_sync = sync;
      u_if.i_din        = din;
      @(posedge clk);
      #1;
      u_if.i_din_valid  = 1'b0;
      u_if.i_frame_sync = 1'b0;
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      u_if.i_din_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      n_checks++;
      if ({u_if.o_a, u_if.o_b, u_if.o_a_valid, u_if.o_b_valid, u_if.o_frame_done, u_if.o_sync_err} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_outputs got=%b want=000000",
                  {u_if.o_a, u_if.o_b, u_if.o_a_valid, u_if.o_b_valid, u_if.o_frame_done, u_if.o_sync_err});
      end
      n_checks++;
      if (u_if.o_err_count !== 8'd0) begin
         n_fail++; $display("FAIL reset_err_count got=%0d want=0", u_if.o_err_count);
      end
      @(negedge clk);
      rst = 1'b0;
      // Mid-stream: capture an A word, then assert reset between clock edges.
      beat(1'b1, 1'b1);
      n_checks++;
      if (u_if.o_a !== 1'b1 || u_if.o_a_valid !== 1'b1) begin
         n_fail++; $display("FAIL pre_reset_a got a=%b a_valid=%b want 1 1", u_if.o_a, u_if.o_a_valid);
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (u_if.o_a !== 1'b0 || u_if.o_a_valid !== 1'b0) begin
         n_fail++; $display("FAIL async_reset got a=%b a_valid=%b want 0 0", u_if.o_a, u_if.o_a_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      // Back in HUNT a sync=0 beat is silently discarded (EXP_B would capture B).
      beat(1'b0, 1'b1);
      n_checks++;
      if (u_if.o_sync_err !== 1'b0 || u_if.o_b_valid !== 1'b0 || u_if.o_b !== 1'b0) begin
         n_fail++; $display("FAIL reset_to_hunt got sync_err=%b b_valid=%b b=%b want 0 0 0",
                            u_if.o_sync_err, u_if.o_b_valid, u_if.o_b);
      end
   endtask

   task automatic test_clean_frames();
      logic [1:0] sync_v [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [1:0] din_v  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [4:0] exp_v  [4];   // {a, b, a_valid, b_valid, frame_done}
      int         n_done = 0;
      int         n_err  = 0;
      exp_v = '{5'b10100, 5'b10011, 5'b00100, 5'b01011};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         beat(sync_v[i][0], din_v[i][0]);
         n_done += int'(u_if.o_frame_done);
         n_err  += int'(u_if.o_sync_err);
         n_checks++;
         if ({u_if.o_a, u_if.o_b, u_if.o_a_valid, u_if.o_b_valid, u_if.o_frame_done} !== exp_v[i]) begin
            n_fail++;
            $display("FAIL clean_beat%0d got=%b want=%b", i,
                     {u_if.o_a, u_if.o_b, u_if.o_a_valid, u_if.o_b_valid, u_if.o_frame_done}, exp_v[i]);
         end
      end
      n_checks++;
      if (n_done != 2 || n_err != 0) begin
         n_fail++; $display("FAIL clean_totals got done=%0d err=%0d want done=2 err=0", n_done, n_err);
      end
   endtask

   task automatic test_hunt_discard();
      int n_av = 0;
      int n_err = 0;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         beat(i == 2, 1'b1);
         n_av  += int'(u_if.o_a_valid);
         n_err += int'(u_if.o_sync_err);
      end
      n_checks++;
      if (n_av != 1 || n_err != 0 || u_if.o_a !== 1'b1 || u_if.o_b !== 1'b0) begin
         n_fail++; $display("FAIL hunt_discard got a_valid_cnt=%0d err=%0d a=%b b=%b want 1 0 1 0",
                            n_av, n_err, u_if.o_a, u_if.o_b);
      end
   endtask

   task automatic test_missing_b();
      do_reset();
      beat(1'b1, 1'b0);
      beat(1'b0, 1'b1);   // b = 1
      beat(1'b1, 1'b0);
      beat(1'b1, 1'b1);   // B slot missing
      n_checks++;
      if ({u_if.o_sync_err, u_if.o_a, u_if.o_a_valid, u_if.o_b_valid, u_if.o_b} !== 5'b11101) begin
         n_fail++; $display("FAIL missing_b got {err,a,av,bv,b}=%b want=11101",
                            {u_if.o_sync_err, u_if.o_a, u_if.o_a_valid, u_if.o_b_valid, u_if.o_b});
      end
      // Still in EXP_B: a sync=0 beat completes the frame.
      beat(1'b0, 1'b0);
      n_checks++;
      if ({u_if.o_sync_err, u_if.o_b_valid, u_if.o_frame_done, u_if.o_b} !== 4'b0110) begin
         n_fail++; $display("FAIL missing_b_state got {err,bv,done,b}=%b want=0110",
                            {u_if.o_sync_err, u_if.o_b_valid, u_if.o_frame_done, u_if.o_b});
      end
   endtask

   task automatic test_lost_lock();
      do_reset();
      beat(1'b1, 1'b1);
      beat(1'b0, 1'b1);
      idle_cycle();
      n_checks++;
      if ({u_if.o_a_valid, u_if.o_b_valid, u_if.o_frame_done, u_if.o_sync_err, u_if.o_a, u_if.o_b} !== 6'b000011) begin
         n_fail++; $display("FAIL idle_gap got=%b want=000011",
                            {u_if.o_a_valid, u_if.o_b_valid, u_if.o_frame_done, u_if.o_sync_err, u_if.o_a, u_if.o_b});
      end
      beat(1'b0, 1'b0);   // lost lock in EXP_A
      n_checks++;
      if ({u_if.o_sync_err, u_if.o_a_valid, u_if.o_b_valid, u_if.o_a, u_if.o_b} !== 5'b10011) begin
         n_fail++; $display("FAIL lost_lock got {err,av,bv,a,b}=%b want=10011",
                            {u_if.o_sync_err, u_if.o_a_valid, u_if.o_b_valid, u_if.o_a, u_if.o_b});
      end
      beat(1'b0, 1'b0);   // HUNT discards without error
      n_checks++;
      if (u_if.o_sync_err !== 1'b0 || u_if.o_b_valid !== 1'b0) begin
         n_fail++; $display("FAIL lost_lock_hunt got err=%b bv=%b want 0 0", u_if.o_sync_err, u_if.o_b_valid);
      end
      // frame_sync without din_valid must not capture.
      @(negedge clk);
      u_if.i_frame_sync = 1'b1;
      u_if.i_din        = 1'b0;
      @(posedge clk);
      #1;
      u_if.i_frame_sync = 1'b0;
      n_checks++;
      if (u_if.o_a_valid !== 1'b0 || u_if.o_a !== 1'b1) begin
         n_fail++; $display("FAIL sync_no_valid got av=%b a=%b want 0 1", u_if.o_a_valid, u_if.o_a);
      end
   endtask

   task automatic test_err_count();
      int         n_err = 0;
      logic [7:0] exp_5;
      logic [7:0] exp_300;
`ifdef TDM_DEMUX_ERRCNT_EN
      exp_5   = 8'd5;
      exp_300 = 8'd255;
`else
      exp_5   = 8'd0;
      exp_300 = 8'd0;
`endif
      do_reset();
      beat(1'b1, 1'b0);
      for (int i = 0; i < 300; i++) begin
         beat(1'b1, i[0]);
         n_err += int'(u_if.o_sync_err);
         if (i == 4) begin
            n_checks++;
            if (u_if.o_err_count !== exp_5) begin
               n_fail++; $display("FAIL err_count_5 got=%0d want=%0d", u_if.o_err_count, exp_5);
            end
         end
      end
      n_checks++;
      if (u_if.o_err_count !== exp_300) begin
         n_fail++; $display("FAIL err_count_300 got=%0d want=%0d", u_if.o_err_count, exp_300);
      end
      n_checks++;
      if (n_err != 300) begin
         n_fail++; $display("FAIL err_pulses got=%0d want=300", n_err);
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (u_if.o_err_count !== 8'd0) begin
         n_fail++; $display("FAIL err_count_reset got=%0d want=0", u_if.o_err_count);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      u_if.i_din        = 1'b0;
      u_if.i_din_valid  = 1'b0;
      u_if.i_frame_sync = 1'b0;
      #1;
      test_reset();
      test_clean_frames();
      test_hunt_discard();
      test_missing_b();
      test_lost_lock();
      test_err_count();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Two-channel time-division demultiplexer, the receive-side counterpart of the 2:1 `mux` (output `f`, channel select `sel`). It takes a word stream in which channel A and channel B words alternate, with A marked by `frame_sync`. It locks onto the frame with a small state machine and steers each word into a registered per-channel output with a one-cycle valid strobe. It also flags framing errors and pulses once per completed A/B frame.

## Interface
Parameters:
- `WIDTH`, default 1: data word width. Default 1 matches the single-bit `mux` datapath.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `din`, in, WIDTH: incoming multiplexed word.
- `din_valid`, in, 1: `din` is meaningful this cycle. Cycles with it low are ignored.
- `frame_sync`, in, 1: qualified by `din_valid`; marks the current word as channel A.
- `a`, out, WIDTH: last captured channel-A word; holds between captures.
- `b`, out, WIDTH: last captured channel-B word; holds between captures.
- `a_valid`, out, 1: one-cycle pulse when `a` is updated.
- `b_valid`, out, 1: one-cycle pulse when `b` is updated.
- `frame_done`, out, 1: one-cycle pulse, coincident with `b_valid`, when an A then B pair has completed.
- `sync_err`, out, 1: one-cycle pulse on a framing violation.
- `err_count`, out, 8: saturating framing-error count (see Configuration).

## Operation
- States: `HUNT`, `EXP_B`, `EXP_A`. Reset state is `HUNT`.
- A beat is a cycle with `din_valid` = 1; all transitions below occur only on beats.
- `HUNT`:
  - beat with `frame_sync` = 1: capture `din` into `a`, pulse `a_valid`, go to `EXP_B`.
  - beat with `frame_sync` = 0: discard the word, stay in `HUNT`, no error.
- `EXP_B`:
  - beat with `frame_sync` = 0: capture into `b`, pulse `b_valid` and `frame_done`, go to `EXP_A`.
  - beat with `frame_sync` = 1: B slot missing. Pulse `sync_err`, capture the word into `a`, pulse `a_valid`, stay in `EXP_B`. `b` is unchanged.
- `EXP_A`:
  - beat with `frame_sync` = 1: capture into `a`, pulse `a_valid`, go to `EXP_B`.
  - beat with `frame_sync` = 0: lost lock. Pulse `sync_err`, discard the word, go to `HUNT`.
- At most one of `a_valid` / `b_valid` is high in any cycle.
- Idle gaps (`din_valid` = 0) in any state hold state and data; all pulses are 0.

## Timing
- All outputs are registered. A beat at edge N is visible on `a`/`b` and on the strobes after edge N; latency is 1 cycle.
- Back-to-back beats are supported at one word per cycle; throughput is 1 word/cycle.
- Reset: `a` = 0, `b` = 0, all strobes 0, `err_count` = 0, state `HUNT`.
- Reset asserted mid-frame clears everything immediately, without waiting for a clock edge.
- After reset deasserts, the first word captured is the next beat with `frame_sync` = 1.
- `frame_sync` without `din_valid` is ignored.

## Configuration
- Macro: `TDM_DEMUX_ERRCNT_EN`.
- Defined:
  - `err_count` increments by 1 on every `sync_err` pulse and saturates at 255.
  - The increment is registered in the same cycle as the pulse.
  - Cleared only by `rst`.
- Undefined:
  - The counter logic is compiled out and `err_count` is tied to 8'd0.
  - `sync_err` behaviour is unchanged.

## Test plan
- Reset check: assert `rst` mid-stream. Required: all outputs go to 0 without waiting for a clock edge, and the block returns to `HUNT`.
- Clean frames:
  - Stimulus: WIDTH = 1; beats (sync=1, din=1), (0, 0), (1, 0), (0, 1).
  - Required: `a` = 1 then 0; `b` = 0 then 1; two `frame_done` pulses; no `sync_err`.
- Hunt discard: two beats with sync=0, then (sync=1, din=1). Required: first two words ignored, `a_valid` once, no `sync_err`.
- Missing B: beats (sync=1, din=0), (sync=1, din=1). Required: second beat pulses `sync_err` and sets `a` = 1; `b` unchanged; state `EXP_B`.
- Lost lock and idle gaps: full frame, then an idle cycle, then beat (sync=0). Required: during the idle cycle no strobe fires and state holds; the sync=0 beat pulses `sync_err`, is discarded, and state returns to `HUNT`.
- `TDM_DEMUX_ERRCNT_EN` defined: force 300 framing errors. Required: `err_count` = 255. With the macro undefined, `err_count` stays 0.
